inference_seq_ctrl: RTL and testbench

//   Sequencer in front of the MLP network (hidden_layer -> output_layer chain).

---
 rtl/inference_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_inference_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_seq_ctrl.sv
// Sequencer in front of the MLP network: accepts one vector, pulses start, waits for done
// under a watchdog, and returns class/tag/error through a valid/ready port with saturating counters.
module inference_seq_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IN_DIM      = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W*IN_DIM-1:0] in_data,
    output logic [DATA_W*IN_DIM-1:0] net_bus_in,
    output logic                     net_start,
    input  logic                     net_done,
    input  logic [3:0]               net_class_idx,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_class,
    output logic [7:0]               res_tag,
    output logic                     res_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         infer_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int unsigned BUS_W = DATA_W * IN_DIM;
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [7:0]       tag_ctr;
    logic             done_d;
    logic             done_rise;
    logic             accept;
    logic             done_hit;
    logic             tmo_hit;
    logic             res_take;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle events; a done already high on WAIT entry never produces a rise
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_hit  = 1'b0;
        tmo_hit   = 1'b0;
        res_take  = 1'b0;
        done_rise = net_done & ~done_d;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (done_rise) begin
                    done_hit  = 1'b1;
                    state_nxt = ST_RESULT;
                end else if (timer == TMR_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_take  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            net_start   <= 1'b0;
            res_valid   <= 1'b0;
            net_bus_in  <= '0;
            res_class   <= '0;
            res_tag     <= '0;
            res_err     <= 1'b0;
            tag_ctr     <= '0;
            timer       <= '0;
            done_d      <= 1'b0;
            infer_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            done_d    <= net_done;
            in_ready  <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            net_start <= (state_nxt == ST_LAUNCH);
            res_valid <= (state_nxt == ST_RESULT);

            if (accept) begin
                net_bus_in <= BUS_W'(in_data);
                res_tag    <= tag_ctr;
                tag_ctr    <= tag_ctr + 8'd1;
            end

            if (state == ST_LAUNCH) begin
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + TMR_W'(1);
            end

            if (done_hit) begin
                res_class <= net_class_idx;
                res_err   <= 1'b0;
            end else if (tmo_hit) begin
                res_class <= 4'hF;
                res_err   <= 1'b1;
            end

            if (res_take) begin
                if (!res_err) begin
                    if (infer_cnt != CNT_MAX) infer_cnt <= infer_cnt + CNT_W'(1);
                end else begin
                    if (timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inference_seq_ctrl.sv
// Directed self-checking bench for inference_seq_ctrl (short watchdog, 4-bit counters).
module tb_inference_seq_ctrl;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned IN_DIM      = 16;
    localparam int unsigned TIMEOUT_CYC = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned BUS_W       = DATA_W * IN_DIM;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic [BUS_W-1:0] net_bus_in;
    logic             net_start;
    logic             net_done;
    logic [3:0]       net_class_idx;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_class;
    logic [7:0]       res_tag;
    logic             res_err;
    logic             busy;
    logic [CNT_W-1:0] infer_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    inference_seq_ctrl #(
        .DATA_W(DATA_W), .IN_DIM(IN_DIM), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .net_bus_in(net_bus_in), .net_start(net_start),
        .net_done(net_done), .net_class_idx(net_class_idx),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_tag(res_tag), .res_err(res_err),
        .busy(busy), .infer_cnt(infer_cnt), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; observe and drive 1 ns after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a vector in IDLE and advance into LAUNCH
    task automatic launch(input logic [BUS_W-1:0] data);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (net_start !== 1'b0) begin errors++; $display("FAIL reset_net_start: got %0b want 0", net_start); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (net_bus_in !== '0) begin errors++; $display("FAIL reset_bus: got %0h want 0", net_bus_in); end
        checks++; if ({res_tag, res_class, res_err} !== 13'd0) begin errors++; $display("FAIL reset_res_fields: got %0h want 0", {res_tag, res_class, res_err}); end
        checks++; if ({infer_cnt, timeout_cnt} !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0h want 0", {infer_cnt, timeout_cnt}); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got ready=%0b busy=%0b want 1/0", in_ready, busy); end
    endtask

    // Done rises 20 cycles after the start cycle with class 3
    task automatic test_single();
        logic [BUS_W-1:0] d;
        int starts;
        d = {IN_DIM{8'hA5}};
        launch(d);
        checks++; if (net_start !== 1'b1) begin errors++; $display("FAIL single_start: got %0b want 1", net_start); end
        checks++; if (net_bus_in !== d) begin errors++; $display("FAIL single_bus: got %0h want %0h", net_bus_in, d); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_launch_flags: got ready=%0b busy=%0b want 0/1", in_ready, busy); end
        starts = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (net_start === 1'b1) starts++;
            if (res_valid !== 1'b0) starts += 100;
            if (k == 20) begin
                net_done      = 1'b1;
                net_class_idx = 4'd3;
            end
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL single_wait_quiet: got %0d extra events want 0", starts); end
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %0b want 1", res_valid); end
        checks++; if (res_class !== 4'd3) begin errors++; $display("FAIL single_class: got %0h want 3", res_class); end
        checks++; if (res_tag !== 8'd0) begin errors++; $display("FAIL single_tag: got %0h want 0", res_tag); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", res_err); end
        checks++; if (net_bus_in !== d) begin errors++; $display("FAIL single_bus_hold: got %0h want %0h", net_bus_in, d); end
        net_class_idx = 4'd0;
        handshake();
        net_done = 1'b0;
        checks++; if (infer_cnt !== 4'd1) begin errors++; $display("FAIL single_infer_cnt: got %0d want 1", infer_cnt); end
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle: got valid=%0b ready=%0b want 0/1", res_valid, in_ready); end
    endtask

    // Result held for 10 cycles of backpressure while another vector is offered
    task automatic test_backpressure();
        logic [BUS_W-1:0] d;
        int bad;
        d = {IN_DIM{8'h3C}};
        launch(d);
        tick();
        tick();
        net_done      = 1'b1;
        net_class_idx = 4'd7;
        tick();
        net_class_idx = 4'd2;
        in_valid      = 1'b1;
        in_data       = {IN_DIM{8'hEE}};
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid !== 1'b1 || res_class !== 4'd7 || res_tag !== 8'd1 || res_err !== 1'b0) bad++;
            if (in_ready !== 1'b0 || net_start !== 1'b0 || net_bus_in !== d) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        checks++; if (res_class !== 4'd7 || res_tag !== 8'd1) begin errors++; $display("FAIL bp_fields: got class=%0h tag=%0h want 7/1", res_class, res_tag); end
        in_valid = 1'b0;
        handshake();
        net_done = 1'b0;
        checks++; if (infer_cnt !== 4'd2) begin errors++; $display("FAIL bp_infer_cnt: got %0d want 2", infer_cnt); end
        checks++; if (net_bus_in !== d) begin errors++; $display("FAIL bp_bus_unchanged: got %0h want %0h", net_bus_in, d); end
    endtask

    // Watchdog: result appears TIMEOUT_CYC cycles after the start pulse ends
    task automatic test_timeout();
        int n;
        launch({IN_DIM{8'h11}});
        n = 0;
        while (n < 200 && res_valid !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (n !== TIMEOUT_CYC + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT_CYC + 1); end
        checks++; if (res_class !== 4'hF || res_err !== 1'b1) begin errors++; $display("FAIL timeout_fields: got class=%0h err=%0b want F/1", res_class, res_err); end
        checks++; if (res_tag !== 8'd2) begin errors++; $display("FAIL timeout_tag: got %0h want 2", res_tag); end
        handshake();
        checks++; if (timeout_cnt !== 4'd1 || infer_cnt !== 4'd2) begin errors++; $display("FAIL timeout_counters: got t=%0d i=%0d want 1/2", timeout_cnt, infer_cnt); end
    endtask

    // Done rising on the watchdog's terminal cycle wins
    task automatic test_done_at_terminal();
        launch({IN_DIM{8'h22}});
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            tick();
            if (k == TIMEOUT_CYC) begin
                net_done      = 1'b1;
                net_class_idx = 4'd9;
            end
        end
        tick();
        checks++; if (res_valid !== 1'b1 || res_class !== 4'd9 || res_err !== 1'b0) begin errors++; $display("FAIL terminal_done_wins: got v=%0b class=%0h err=%0b want 1/9/0", res_valid, res_class, res_err); end
        handshake();
        net_done = 1'b0;
        checks++; if (infer_cnt !== 4'd3 || timeout_cnt !== 4'd1) begin errors++; $display("FAIL terminal_counters: got i=%0d t=%0d want 3/1", infer_cnt, timeout_cnt); end
    endtask

    // Done held high from before launch is ignored until it falls and rises again
    task automatic test_stale_done();
        int early;
        net_done      = 1'b1;
        net_class_idx = 4'd5;
        tick();
        launch({IN_DIM{8'h44}});
        early = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (res_valid !== 1'b0) early++;
            if (k == 3) net_done = 1'b0;
            if (k == 8) begin
                net_done      = 1'b1;
                net_class_idx = 4'd12;
            end
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL stale_early_result: got %0d want 0", early); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_class !== 4'd12) begin errors++; $display("FAIL stale_class: got v=%0b class=%0h want 1/c", res_valid, res_class); end
        checks++; if (res_tag !== 8'd4) begin errors++; $display("FAIL stale_tag: got %0h want 4", res_tag); end
        handshake();
        net_done = 1'b0;
        checks++; if (infer_cnt !== 4'd4) begin errors++; $display("FAIL stale_infer_cnt: got %0d want 4", infer_cnt); end
    endtask

    // Asynchronous reset in the middle of WAIT
    task automatic test_reset_in_wait();
        int starts;
        launch({IN_DIM{8'h77}});
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (net_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstwait_flags: got s=%0b v=%0b b=%0b want 0", net_start, res_valid, busy); end
        checks++; if (net_bus_in !== '0 || res_tag !== 8'd0 || res_class !== 4'd0 || res_err !== 1'b0) begin errors++; $display("FAIL rstwait_data: got tag=%0h class=%0h want 0", res_tag, res_class); end
        checks++; if (infer_cnt !== 4'd0 || timeout_cnt !== 4'd0) begin errors++; $display("FAIL rstwait_counters: got i=%0d t=%0d want 0", infer_cnt, timeout_cnt); end
        starts = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (net_start !== 1'b0 || res_valid !== 1'b0) starts++;
        end
        rst_n = 1'b1;
        tick();
        if (net_start !== 1'b0 || res_valid !== 1'b0) starts++;
        checks++; if (starts !== 0) begin errors++; $display("FAIL rstwait_no_emit: got %0d want 0", starts); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %0b want 1", in_ready); end
    endtask

    // 257 back-to-back inferences at minimum loop: tag wrap and counter saturation
    task automatic test_back_to_back();
        int bad_ready, bad_start, bad_tag, bad_class;
        logic [7:0] exp_tag;
        logic [3:0] exp_cls;
        bad_ready = 0; bad_start = 0; bad_tag = 0; bad_class = 0;
        in_valid = 1'b1;
        in_data  = {IN_DIM{8'h00}};
        for (int i = 0; i <= 256; i++) begin
            exp_tag = 8'(i);
            exp_cls = 4'(i % 15);
            if (in_ready !== 1'b1) bad_ready++;
            tick();
            in_valid = 1'b0;
            if (net_start !== 1'b1 || net_bus_in !== {IN_DIM{exp_tag}}) bad_start++;
            if (i == 0) begin
                checks++; if (res_tag !== 8'd0) begin errors++; $display("FAIL b2b_first_tag: got %0h want 0", res_tag); end
            end
            tick();
            net_done      = 1'b1;
            net_class_idx = exp_cls;
            tick();
            if (res_valid !== 1'b1 || res_tag !== exp_tag) bad_tag++;
            if (res_class !== exp_cls || res_err !== 1'b0) bad_class++;
            if (i == 256) begin
                checks++; if (res_tag !== 8'h00) begin errors++; $display("FAIL b2b_wrap_tag: got %0h want 0", res_tag); end
            end
            if (i == 255) begin
                checks++; if (res_tag !== 8'hFF) begin errors++; $display("FAIL b2b_tag_ff: got %0h want ff", res_tag); end
            end
            res_ready = 1'b1;
            net_done  = 1'b0;
            if (i < 256) begin
                in_valid = 1'b1;
                in_data  = {IN_DIM{8'(i + 1)}};
            end
            tick();
            res_ready = 1'b0;
            if (i == 10) begin
                checks++; if (infer_cnt !== 4'd11) begin errors++; $display("FAIL b2b_cnt_mid: got %0d want 11", infer_cnt); end
            end
        end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL b2b_min_loop_ready: got %0d bad want 0", bad_ready); end
        checks++; if (bad_start !== 0) begin errors++; $display("FAIL b2b_start_bus: got %0d bad want 0", bad_start); end
        checks++; if (bad_tag !== 0) begin errors++; $display("FAIL b2b_tags: got %0d bad want 0", bad_tag); end
        checks++; if (bad_class !== 0) begin errors++; $display("FAIL b2b_classes: got %0d bad want 0", bad_class); end
        checks++; if (infer_cnt !== 4'hF) begin errors++; $display("FAIL b2b_infer_sat: got %0d want 15", infer_cnt); end
        checks++; if (timeout_cnt !== 4'd0) begin errors++; $display("FAIL b2b_timeout_cnt: got %0d want 0", timeout_cnt); end
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        net_done      = 1'b0;
        net_class_idx = 4'd0;
        res_ready     = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_done_at_terminal();
        test_stale_done();
        test_reset_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
